// File: rtl/conv_layer2_feeder.sv
// Feeds filter rows and assembled 14-row ifmap columns into the layer-2 PE array.
// Optional zero-padding columns before/after each frame: define FEEDER_ZERO_PAD_EN.
module conv_layer2_feeder #(
  parameter int COLS = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          filt_valid,
  output logic          filt_ready,
  input  logic [47:0]   filt_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [31:0]   wr_data,
  output logic [111:0]  Ifmap_shift_in_0,
  output logic [111:0]  Ifmap_shift_in_1,
  output logic [111:0]  Ifmap_shift_in_2,
  output logic [111:0]  Ifmap_shift_in_3,
  output logic [47:0]   Filtr_in_0,
  output logic [47:0]   Filtr_in_1,
  output logic [47:0]   Filtr_in_2,
  output logic          en,
  output logic          busy,
  output logic          done
);

  localparam int ROWS = 14;
  localparam int CW   = $clog2(COLS + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_FILT, PAD_PRE, STREAM, PAD_POST, DONE
  } state_t;

  state_t         state;
  logic [1:0]     beat_cnt;
  logic [3:0]     row_cnt;
  logic [CW-1:0]  col_cnt;
  logic [31:0]    asm_q [ROWS];
  logic [111:0]   col_next [4];

  logic accept_filt;
  logic accept_pix;

  assign accept_filt = filt_valid & filt_ready;
  assign accept_pix  = wr_valid & wr_ready;

  // Full column per channel; the last row bypasses the assembly register so the
  // column can be emitted on the edge that accepts it.
  // NOTE: every combinational output gets a default before the loops, so no latch is inferred.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      col_next[k] = '0;
      for (int r = 0; r < ROWS; r++) begin
        col_next[k][111-8*r -: 8] = (r == ROWS-1) ? wr_data[31-8*k -: 8]
                                                  : asm_q[r][31-8*k -: 8];
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      beat_cnt         <= '0;
      row_cnt          <= '0;
      col_cnt          <= '0;
      // NOTE: the assembly register is reset too, so a partial column never survives into a new frame.
      for (int r = 0; r < ROWS; r++) asm_q[r] <= '0;
      Ifmap_shift_in_0 <= '0;
      Ifmap_shift_in_1 <= '0;
      Ifmap_shift_in_2 <= '0;
      Ifmap_shift_in_3 <= '0;
      Filtr_in_0       <= '0;
      Filtr_in_1       <= '0;
      Filtr_in_2       <= '0;
      filt_ready       <= 1'b0;
      wr_ready         <= 1'b0;
      en               <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      en   <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD_FILT;
            filt_ready <= 1'b1;
            busy       <= 1'b1;
            beat_cnt   <= '0;
          end
        end

        LOAD_FILT: begin
          if (accept_filt) begin
            case (beat_cnt)
              2'd0:    Filtr_in_0 <= filt_data;
              2'd1:    Filtr_in_1 <= filt_data;
              default: Filtr_in_2 <= filt_data;
            endcase
            beat_cnt <= beat_cnt + 2'd1;
            if (beat_cnt == 2'd2) begin
              beat_cnt   <= '0;
              filt_ready <= 1'b0;
              row_cnt    <= '0;
              col_cnt    <= '0;
`ifdef FEEDER_ZERO_PAD_EN
              state            <= PAD_PRE;
              en               <= 1'b1;
              Ifmap_shift_in_0 <= '0;
              Ifmap_shift_in_1 <= '0;
              Ifmap_shift_in_2 <= '0;
              Ifmap_shift_in_3 <= '0;
`else
              state    <= STREAM;
              wr_ready <= 1'b1;
`endif
            end
          end
        end

`ifdef FEEDER_ZERO_PAD_EN
        PAD_PRE: begin
          state    <= STREAM;
          wr_ready <= 1'b1;
        end
`endif

        STREAM: begin
          if (col_cnt == CW'(COLS)) begin
            // Last column is on the outputs this cycle; leave the stream now.
`ifdef FEEDER_ZERO_PAD_EN
            state            <= PAD_POST;
            en               <= 1'b1;
            Ifmap_shift_in_0 <= '0;
            Ifmap_shift_in_1 <= '0;
            Ifmap_shift_in_2 <= '0;
            Ifmap_shift_in_3 <= '0;
`else
            state <= DONE;
            done  <= 1'b1;
`endif
          end else if (accept_pix) begin
            asm_q[row_cnt] <= wr_data;
            if (row_cnt == 4'(ROWS-1)) begin
              row_cnt          <= '0;
              col_cnt          <= col_cnt + 1'b1;
              en               <= 1'b1;
              Ifmap_shift_in_0 <= col_next[0];
              Ifmap_shift_in_1 <= col_next[1];
              Ifmap_shift_in_2 <= col_next[2];
              Ifmap_shift_in_3 <= col_next[3];
              if (col_cnt == CW'(COLS-1)) wr_ready <= 1'b0;
            end else begin
              row_cnt <= row_cnt + 4'd1;
            end
          end
        end

`ifdef FEEDER_ZERO_PAD_EN
        PAD_POST: begin
          state <= DONE;
          done  <= 1'b1;
        end
`endif

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          filt_ready <= 1'b0;
          wr_ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/conv_layer2_feeder.md
CONV_LAYER2_FEEDER -- requirements
Module: conv_layer2_feeder

Interface
REQ-001 Parameter: COLS, 14, ifmap columns per frame (14 rows per column fixed).
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle frame request; honoured only in IDLE.
REQ-005 filt_valid / filt_ready  input / output  1 / 1  filter-load handshake.
REQ-006 filt_data  input  48  one filter row: 4 channels x 3 taps x 4 bit, channel 0 in [47:36].
REQ-007 wr_valid / wr_ready  input / output  1 / 1  pixel handshake.
REQ-008 wr_data  input  32  one pixel position for 4 channels, channel k in [31-8k -: 8].
REQ-009 Ifmap_shift_in_0..3  output  112 each  column for channel k; row r in [111-8r -: 8].
REQ-010 Filtr_in_0..2  output  48 each  held filter rows.
REQ-011 en  output  1  column-valid strobe to the PE array.
REQ-012 busy / done  output  1 / 1  frame in progress; one-cycle completion pulse.

Function
REQ-013 FSM states: IDLE, LOAD_FILT, PAD_PRE, STREAM, PAD_POST, DONE.
REQ-014 IDLE -> LOAD_FILT on start; start in any other state is ignored.
REQ-015 LOAD_FILT: filt_ready=1; beats 0,1,2 are written to Filtr_in_0, _1 and _2 respectively; after beat 2 the FSM moves to PAD_PRE, or to STREAM when padding is compiled out.
REQ-016 Filtr_in_* hold their value until overwritten by the next frame's LOAD_FILT.
REQ-017 STREAM: wr_ready=1; pixels arrive column-major, row 0 first; a 4-bit row counter counts 0..13.
REQ-018 Each accepted pixel r is stored into row slot r of a 14 x 32-bit assembly register.
REQ-019 When row 13 is accepted, at the next edge Ifmap_shift_in_0..3 load the full column (row 13 taken from that beat's wr_data), en=1 for exactly that cycle, and the row counter wraps to 0.
REQ-020 Latency is one cycle from the accepting edge of row 13 to en high, and wr_ready stays 1, so columns can be delivered back to back every 14 cycles with no bubble.
REQ-021 Ifmap_shift_in_* hold their value whenever en=0.
REQ-022 A column counter counts emitted columns; once column COLS-1 is emitted the FSM moves to PAD_POST, or to DONE when padding is compiled out.
REQ-023 Beats with wr_valid=1 outside STREAM, or filt_valid=1 outside LOAD_FILT, are not accepted and cause no state change.
REQ-024 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-025 busy=1 in every state except IDLE.
REQ-026 A wr_valid gap mid-column stalls the row counter; the partial column is retained.

Reset
REQ-027 Asserting rst_n low at any time, including mid-column or mid-filter-load, forces IDLE immediately.
REQ-028 Reset clears all counters, the assembly register, Ifmap_shift_in_*, Filtr_in_*, en, busy and done to 0, and drives filt_ready=0 and wr_ready=0.
REQ-029 After rst_n is released, only a new start begins a frame; partial data from before reset is discarded.

Configuration
REQ-030 Macro FEEDER_ZERO_PAD_EN.
REQ-031 When FEEDER_ZERO_PAD_EN is defined, PAD_PRE and PAD_POST each last one cycle with en=1, Ifmap_shift_in_* = 0 and wr_ready=0, giving COLS+2 en pulses per frame.
REQ-032 When FEEDER_ZERO_PAD_EN is undefined, the PAD states are unreachable and give no implementation cost, and a frame produces exactly COLS en pulses.

Verification
REQ-033 Reset mid-STREAM (row counter 7) -> all outputs 0 next cycle; a following frame's first en carries only new data.
REQ-034 Filter beats 48'hAAA..., 48'h555..., 48'h123456789ABC -> Filtr_in_0/1/2 equal those values and stay stable through STREAM.
REQ-035 Padding off, 14 columns with pixel value {col,row} on every channel, wr_valid held high -> 14 en pulses spaced 14 cycles apart, each Ifmap row r = {col,row}, done pulses one cycle after the last en.
REQ-036 Padding on, same stimulus -> 16 en pulses; the first and last carry all-zero columns, wr_ready=0 during both pads.
REQ-037 wr_valid low for 5 cycles after row 6 -> en is delayed by 5 cycles and the column content is unchanged.
REQ-038 start pulsed during STREAM, and wr_valid driven during LOAD_FILT -> both ignored, with column and filter contents unaffected.
